irq_capture: RTL and testbench

IRQ_CAPTURE -- requirements
Module: irq_capture

---
 rtl/irq_capture.sv | 123 ++++++++++++
 tb/tb_irq_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture.sv
// ---------------------------------------------------------------------------
// irq_capture
//   Captures four interrupt sources into a pending register, exposes the
//   unmasked pending set to an external 4-to-2 priority encoder, and presents
//   one request at a time to a consumer using a req/ack handshake.
//
//   Parameters
//     EDGE_MODE  1 = rising-edge capture of irq_in, 0 = level capture
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     rst_n      asynchronous active-low reset
//     irq_in     interrupt sources (bit 3 highest priority)
//     mask       1 = source hidden from the encoder view (still latched)
//     pend       pending & ~mask, feeds the external encoder
//     enc_out    encoder index for pend
//     enc_valid  encoder valid (pend != 0)
//     irq_req    request to the consumer
//     irq_id     index of the presented request
//     irq_ack    consumer acknowledge of the presented request
//     overflow   sticky per-source flag: an edge was coalesced into an
//                already-pending request
//     ovf_clr    synchronous clear of all overflow bits
// ---------------------------------------------------------------------------
module irq_capture #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    output logic [3:0] pend,
    input  logic [1:0] enc_out,
    input  logic       enc_valid,
    output logic       irq_req,
    output logic [1:0] irq_id,
    input  logic       irq_ack,
    output logic [3:0] overflow,
    input  logic       ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] irq_d_q;
    logic [3:0] overflow_q, overflow_d;
    logic [1:0] irq_id_q, irq_id_d;
    logic       irq_req_q, irq_req_d;

    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] ovf_set;

    // Capture qualification. In level mode a held source keeps re-setting
    // its pending bit, so coalescing is expected and never flagged.
    generate
        if (EDGE_MODE) begin : g_edge
            assign set     = irq_in & ~irq_d_q;
            assign ovf_set = set & pending_q & ~clr;
        end else begin : g_level
            assign set     = irq_in;
            assign ovf_set = 4'b0000;
        end
    endgenerate

    // Set has priority over the ack clear of the same bit, so a re-edge at
    // the ack edge leaves the source pending for re-request.
    assign pending_d  = set | (pending_q & ~clr);
    // A fresh overflow on a bit wins over a same-cycle clear.
    assign overflow_d = ovf_set | (ovf_clr ? 4'b0000 : overflow_q);

    // Request FSM. Once in REQ the id is frozen until ack, regardless of
    // later arrivals or masking of the presented source.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        clr      = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d  = REQ;
                    irq_id_d = enc_out;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d       = IDLE;
                    clr[irq_id_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 4'b0000;
            irq_d_q    <= 4'b0000;
            overflow_q <= 4'b0000;
            irq_id_q   <= 2'd0;
            irq_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_d_q    <= irq_in;
            overflow_q <= overflow_d;
            irq_id_q   <= irq_id_d;
            irq_req_q  <= irq_req_d;
        end
    end

    assign pend     = pending_q & ~mask;
    assign irq_req  = irq_req_q;
    assign irq_id   = irq_id_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_capture.sv
// ---------------------------------------------------------------------------
// tb_irq_capture
//   Drives an edge-mode and a level-mode irq_capture from shared stimulus.
//   Each DUT gets its own priority encoder built from its pend output.
//   A behavioural model (one per mode) predicts pend/irq_req/irq_id/overflow
//   every cycle; directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_irq_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_in = 4'b0;
    logic [3:0] mask = 4'b0;
    logic       irq_ack = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [3:0] pend_e, pend_l, ovf_e, ovf_l;
    logic [1:0] enc_e, enc_l, id_e, id_l;
    logic       vld_e, vld_l, req_e, req_l;

    always #5 clk = ~clk;

    // Priority encoder: highest set bit wins.
    function automatic logic [1:0] top(input logic [3:0] v);
        top = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) top = i[1:0];
    endfunction

    assign enc_e = top(pend_e);
    assign vld_e = |pend_e;
    assign enc_l = top(pend_l);
    assign vld_l = |pend_l;

    irq_capture #(.EDGE_MODE(1'b1)) u_edge (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .pend(pend_e),
        .enc_out(enc_e), .enc_valid(vld_e), .irq_req(req_e), .irq_id(id_e),
        .irq_ack(irq_ack), .overflow(ovf_e), .ovf_clr(ovf_clr)
    );

    irq_capture #(.EDGE_MODE(1'b0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .pend(pend_l),
        .enc_out(enc_l), .enc_valid(vld_l), .irq_req(req_l), .irq_id(id_l),
        .irq_ack(irq_ack), .overflow(ovf_l), .ovf_clr(ovf_clr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, index 0 = level mode, 1 = edge mode.
    logic [3:0] mp[2];   // pending sources
    logic [3:0] mprev[2];// last sampled irq_in
    logic [3:0] mo[2];   // overflow flags
    logic       mreq[2]; // presenting a request
    logic [1:0] mid[2];  // presented id

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = 4'b0; mprev[m] = 4'b0; mo[m] = 4'b0; mreq[m] = 1'b0; mid[m] = 2'd0;
        end
    endtask

    // Advance the model by one clock using the inputs as they stand now.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] np, no, vis;
            logic       s, c;
            vis = mp[m] & ~mask;
            for (int i = 0; i < 4; i++) begin
                s = (m == 1) ? (irq_in[i] && !mprev[m][i]) : irq_in[i];
                c = mreq[m] && irq_ack && (int'(mid[m]) == i);
                if (s) np[i] = 1'b1;
                else if (c) np[i] = 1'b0;
                else np[i] = mp[m][i];
                if (m == 1 && s && mp[m][i] && !c) no[i] = 1'b1;
                else if (ovf_clr) no[i] = 1'b0;
                else no[i] = mo[m][i];
            end
            if (!mreq[m]) begin
                if (vis != 4'b0) begin
                    mreq[m] = 1'b1;
                    mid[m]  = top(vis);
                end
            end else if (irq_ack) begin
                mreq[m] = 1'b0;
            end
            mp[m] = np;
            mo[m] = no;
            mprev[m] = irq_in;
        end
    endtask

    task automatic compare_all();
        chk("e_pend", pend_e, mp[1] & ~mask);
        chk("e_req", 4'(req_e), 4'(mreq[1]));
        chk("e_id", 4'(id_e), 4'(mid[1]));
        chk("e_ovf", ovf_e, mo[1]);
        chk("l_pend", pend_l, mp[0] & ~mask);
        chk("l_req", 4'(req_l), 4'(mreq[0]));
        chk("l_id", 4'(id_l), 4'(mid[0]));
        chk("l_ovf", ovf_l, mo[0]);
    endtask

    // One clock: model predicts, edge happens, outputs checked just after.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_pend", pend_e, 4'b0000);
        chk("rst_req", 4'(req_e), 4'b0000);
        chk("rst_id", 4'(id_e), 4'b0000);
        chk("rst_ovf", ovf_e, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single edge pulse on source 2.
        irq_in = 4'b0100; cyc();
        chk("t1_pend", pend_e, 4'b0100);
        chk("t1_req0", 4'(req_e), 4'b0000);
        irq_in = 4'b0000; cyc();
        chk("t1_req", 4'(req_e), 4'b0001);
        chk("t1_id", 4'(id_e), 4'b0010);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0;
        chk("t1_pend_ack", pend_e, 4'b0000);
        chk("t1_req_ack", 4'(req_e), 4'b0000);
        cyc();

        // Two sources pending, served high to low with a gap.
        irq_in = 4'b0011; cyc();
        irq_in = 4'b0000; cyc();
        chk("t2_id1", 4'(id_e), 4'b0001);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0;
        chk("t2_gap", 4'(req_e), 4'b0000);
        cyc();
        chk("t2_req2", 4'(req_e), 4'b0001);
        chk("t2_id0", 4'(id_e), 4'b0000);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();

        // Higher source arrives while presenting id 0.
        irq_in = 4'b0001; cyc();
        irq_in = 4'b0000; cyc();
        irq_in = 4'b1000; cyc();
        irq_in = 4'b0000;
        chk("t3_hold_id", 4'(id_e), 4'b0000);
        cyc();
        chk("t3_hold_id2", 4'(id_e), 4'b0000);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();
        chk("t3_id3", 4'(id_e), 4'b0011);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();

        // Masked source latches but stays hidden until unmasked.
        mask = 4'b1000; irq_in = 4'b1000; cyc();
        irq_in = 4'b0000; cyc();
        cyc();
        chk("t4_pend", pend_e, 4'b0000);
        chk("t4_req", 4'(req_e), 4'b0000);
        mask = 4'b0000; cyc();
        chk("t4_req_un", 4'(req_e), 4'b0001);
        chk("t4_id_un", 4'(id_e), 4'b0011);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();

        // Overflow on a coalesced edge, then clear.
        irq_in = 4'b0010; cyc();
        irq_in = 4'b0000; cyc();
        irq_in = 4'b0010; cyc();
        irq_in = 4'b0000;
        chk("t5_ovf", ovf_e, 4'b0010);
        chk("t5_ovf_lvl", ovf_l, 4'b0000);
        ovf_clr = 1'b1; cyc();
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", ovf_e, 4'b0000);
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();

        // Re-edge on the ack edge: set wins, source re-requested.
        irq_in = 4'b0100; cyc();
        irq_in = 4'b0000; cyc();
        irq_in = 4'b0100; irq_ack = 1'b1; cyc();
        irq_in = 4'b0000; irq_ack = 1'b0;
        chk("t6_pend", pend_e, 4'b0100);
        chk("t6_gap", 4'(req_e), 4'b0000);
        chk("t6_ovf", ovf_e, 4'b0000);
        cyc();
        chk("t6_rereq", 4'(req_e), 4'b0001);
        chk("t6_reid", 4'(id_e), 4'b0010);

        // Reset mid-request drops everything at once; a source held high
        // through release is captured on the first edge.
        irq_in = 4'b1001; cyc();
        irq_in = 4'b0100; cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t7_req", 4'(req_e), 4'b0000);
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t7_capt", pend_e, 4'b0100);
        irq_in = 4'b0000;

        // Randomized traffic checked against the model.
        for (int n = 0; n < 600; n++) begin
            irq_in  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            irq_ack = 1'($urandom_range(0, 1));
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
